// File: rtl/sample_fifo.sv
// sample_fifo: single-clock FIFO with a registered read port, an occupancy
// count and sticky overflow/underflow flags. Reset is synchronous, active-high.
module sample_fifo #(
  parameter int BREITE = 8,
  parameter int TIEFE  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [BREITE-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_clr_err,
  output logic [BREITE-1:0] o_data,
  output logic              o_valid,
  output logic [TIEFE:0]    o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int               DEPTH     = 2 ** TIEFE;
  localparam logic [TIEFE:0]   DEPTH_CNT = (TIEFE+1)'(DEPTH);
  localparam logic [TIEFE:0]   CNT_ZERO  = (TIEFE+1)'(0);
  localparam logic [TIEFE:0]   CNT_ONE   = (TIEFE+1)'(1);
  localparam logic [TIEFE-1:0] PTR_ZERO  = TIEFE'(0);
  localparam logic [TIEFE-1:0] PTR_ONE   = TIEFE'(1);
  localparam logic [BREITE-1:0] DATA_ZERO = BREITE'(0);

  logic [BREITE-1:0] mem_r [DEPTH];
  logic [TIEFE-1:0]  wr_ptr_r;
  logic [TIEFE-1:0]  rd_ptr_r;
  logic [TIEFE:0]    count_r;
  logic [TIEFE:0]    count_next_s;
  logic [BREITE-1:0] data_r;
  logic              valid_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Full/empty come straight from the count register, so a push and pop in
  // the same cycle can never pass data through an empty or full FIFO.
  assign full_s    = (count_r == DEPTH_CNT);
  assign empty_s   = (count_r == CNT_ZERO);
  assign push_ok_s = i_push & ~full_s;
  assign pop_ok_s  = i_pop & ~empty_s;

  // Next occupancy from the accepted push/pop combination
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; contents are not reset
  always_ff @(posedge i_clk) begin
    if (push_ok_s && !i_rst) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointers, count, read port and sticky flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      data_r      <= DATA_ZERO;
      valid_r     <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      valid_r <= pop_ok_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        data_r   <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      // A rejection in the same cycle as a clear keeps the flag set
      overflow_r  <= (overflow_r  & ~i_clr_err) | (i_push & full_s);
      underflow_r <= (underflow_r & ~i_clr_err) | (i_pop  & empty_s);
    end
  end

  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_count     = count_r;
  assign o_full      = full_s;
  assign o_empty     = empty_s;
  assign o_overflow  = overflow_r;
  assign o_underflow = underflow_r;

endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: directed scenarios plus randomized traffic, checked against
// a queue-based reference model of the FIFO.
module tb_sample_fifo;

  logic       i_clk;
  logic       i_rst;
  logic       i_push;
  logic [1:0] i_data;
  logic       i_pop;
  logic       i_clr_err;
  logic [1:0] o_data;
  logic       o_valid;
  logic [2:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;
  logic       o_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int mdl_q[$];
  int mdl_data  = 0;
  int mdl_valid = 0;
  int mdl_ovf   = 0;
  int mdl_unf   = 0;

  sample_fifo #(.BREITE(2), .TIEFE(2)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (i_push),
    .i_data     (i_data),
    .i_pop      (i_pop),
    .i_clr_err  (i_clr_err),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare every output
  task automatic step(input logic p, input logic [1:0] d, input logic q,
                      input logic c, input logic r);
    int  sz;
    bit  push_ok;
    bit  pop_ok;
    @(negedge i_clk);
    i_push = p; i_data = d; i_pop = q; i_clr_err = c; i_rst = r;
    @(posedge i_clk);
    if (r) begin
      mdl_q.delete();
      mdl_data = 0; mdl_valid = 0; mdl_ovf = 0; mdl_unf = 0;
    end else begin
      sz      = mdl_q.size();
      push_ok = p && (sz < 4);
      pop_ok  = q && (sz > 0);
      mdl_valid = pop_ok ? 1 : 0;
      if (pop_ok)  mdl_data = mdl_q.pop_front();
      if (push_ok) mdl_q.push_back(int'(d));
      mdl_ovf = ((mdl_ovf != 0) && !c) || (p && sz == 4) ? 1 : 0;
      mdl_unf = ((mdl_unf != 0) && !c) || (q && sz == 0) ? 1 : 0;
    end
    #1;
    check_eq("count",     int'(o_count),     mdl_q.size());
    check_eq("full",      int'(o_full),      (mdl_q.size() == 4) ? 1 : 0);
    check_eq("empty",     int'(o_empty),     (mdl_q.size() == 0) ? 1 : 0);
    check_eq("valid",     int'(o_valid),     mdl_valid);
    check_eq("data",      int'(o_data),      mdl_data);
    check_eq("overflow",  int'(o_overflow),  mdl_ovf);
    check_eq("underflow", int'(o_underflow), mdl_unf);
  endtask

  initial begin
    i_rst = 1'b1; i_push = 1'b0; i_data = 2'd0; i_pop = 1'b0; i_clr_err = 1'b0;

    // reset state
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_empty", int'(o_empty), 1);
    check_eq("rst_full",  int'(o_full),  0);

    // three pushes, three pops in order with one-cycle latency
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    check_eq("fill3_count", int'(o_count), 3);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      check_eq("pop3_data",  int'(o_data),  i);
      check_eq("pop3_valid", int'(o_valid), 1);
    end
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("pop3_valid_drop", int'(o_valid), 0);

    // fill, overflow, drain
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
    check_eq("fill4_full", int'(o_full), 1);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_flag",  int'(o_overflow), 1);
    check_eq("ovf_count", int'(o_count), 4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      check_eq("drain_data", int'(o_data), i);
    end

    // underflow on empty, then clear
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    check_eq("unf_flag",  int'(o_underflow), 1);
    check_eq("unf_valid", int'(o_valid), 0);
    check_eq("ovf_clr",   int'(o_overflow), 0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    check_eq("unf_clr", int'(o_underflow), 0);

    // simultaneous push+pop at count 2 and at full
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check_eq("pp2_count", int'(o_count), 2);
    check_eq("pp2_data",  int'(o_data), 1);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    check_eq("ppf_count", int'(o_count), 3);
    check_eq("ppf_ovf",   int'(o_overflow), 1);
    check_eq("ppf_data",  int'(o_data), 2);

    // push+pop on empty: push wins, pop rejected
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check_eq("ppe_count", int'(o_count), 1);
    check_eq("ppe_valid", int'(o_valid), 0);
    check_eq("ppe_unf",   int'(o_underflow), 1);

    // pointer wrap with alternating push/pop
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      check_eq("wrap_data", int'(o_data), i % 4);
    end
    check_eq("wrap_ovf", int'(o_overflow), 0);
    check_eq("wrap_unf", int'(o_underflow), 0);

    // reset mid-operation discards contents
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i + 1), 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1);
    check_eq("mrst_count", int'(o_count), 0);
    check_eq("mrst_empty", int'(o_empty), 1);
    check_eq("mrst_valid", int'(o_valid), 0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check_eq("mrst_unf", int'(o_underflow), 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 99) < 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
